// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared types and constants for the memory-stage SRAM controller.
// Two halfword phases per 32-bit access: LO carries bits [15:0], HI carries bits [31:16].
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned MEM_BASE_DEFAULT = 32'd1024;

    localparam logic LO_HALF = 1'b0;
    localparam logic HI_HALF = 1'b1;

endpackage

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Loadable down-counter pacing each halfword phase.
// o_last is high while the count is zero; load takes priority over decrement.
module sram_wait_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    input  logic             i_enable,
    output logic             o_last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // next count: reload, decrement toward zero, or hold
    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_value;
        end else if (i_enable && (count_q != {CNT_W{1'b0}})) begin
            count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign o_last = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM stage: turns a 32-bit load/store into two 16-bit SRAM accesses and freezes
// the upstream pipeline until the access reaches DONE.
module mem_stage_sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int SRAM_DATA_WIDTH = 16,
    parameter int WAIT_CYCLES     = 1,
    parameter int MEM_BASE        = MEM_BASE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_Sig_Write_Back_Enable,
    input  logic                       i_Sig_Memory_Read_Enable,
    input  logic                       i_Sig_Memory_Write_Enable,
    input  logic [DATA_WIDTH-1:0]      i_ALU_Result,
    input  logic [DATA_WIDTH-1:0]      i_Value_Rm,
    input  logic [3:0]                 i_Destination,
    output logic                       o_Freeze,
    output logic                       o_Sig_Write_Back_Enable,
    output logic                       o_Sig_Memory_Read_Enable,
    output logic [DATA_WIDTH-1:0]      o_ALU_Result,
    output logic [3:0]                 o_Destination,
    output logic [DATA_WIDTH-1:0]      o_Mem_Read_Data,
    output logic [SRAM_ADDR_WIDTH-1:0] o_SRAM_Addr,
    output logic [SRAM_DATA_WIDTH-1:0] o_SRAM_Write_Data,
    output logic                       o_SRAM_Write_En,
    input  logic [SRAM_DATA_WIDTH-1:0] i_SRAM_Read_Data
);

    localparam int WORD_W = SRAM_ADDR_WIDTH - 1;

    state_e                     state_q, state_d;
    logic [WORD_W-1:0]          word_q, word_d;
    logic                       is_write_q, is_write_d;
    logic [DATA_WIDTH-1:0]      store_q, store_d;
    logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
    logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                       we_q, we_d;

    logic                       mem_req_s;
    logic [WORD_W-1:0]          word_in_s;
    logic                       cnt_load_s;
    logic                       cnt_en_s;
    logic                       cnt_last_s;

    assign mem_req_s = i_Sig_Memory_Read_Enable | i_Sig_Memory_Write_Enable;
    assign word_in_s = WORD_W'((i_ALU_Result - DATA_WIDTH'(MEM_BASE)) >> 2);

    sram_wait_counter #(
        .CNT_W (3)
    ) u_wait_counter (
        .clk          (clk),
        .reset        (reset),
        .i_load       (cnt_load_s),
        .i_load_value (3'(WAIT_CYCLES)),
        .i_enable     (cnt_en_s),
        .o_last       (cnt_last_s)
    );

    // next-state and SRAM-drive logic; outputs are registered so SRAM pins are glitch-free
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        is_write_d = is_write_q;
        store_d    = store_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;

        case (state_q)
            IDLE: begin
                if (mem_req_s) begin
                    // the captured copies keep the access stable if upstream inputs move
                    state_d    = LO;
                    word_d     = word_in_s;
                    is_write_d = i_Sig_Memory_Write_Enable;
                    store_d    = i_Value_Rm;
                    addr_d     = {word_in_s, LO_HALF};
                    we_d       = i_Sig_Memory_Write_Enable;
                    cnt_load_s = 1'b1;
                    if (i_Sig_Memory_Write_Enable) begin
                        wdata_d = i_Value_Rm[SRAM_DATA_WIDTH-1:0];
                    end else begin
                        wdata_d = wdata_q;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LO: begin
                cnt_en_s = 1'b1;
                we_d     = is_write_q;
                if (cnt_last_s) begin
                    state_d    = HI;
                    addr_d     = {word_q, HI_HALF};
                    cnt_load_s = 1'b1;
                    if (is_write_q) begin
                        wdata_d = store_q[DATA_WIDTH-1:SRAM_DATA_WIDTH];
                    end else begin
                        rdata_d[SRAM_DATA_WIDTH-1:0] = i_SRAM_Read_Data;
                    end
                end else begin
                    state_d = LO;
                end
            end
            HI: begin
                cnt_en_s = 1'b1;
                we_d     = is_write_q;
                if (cnt_last_s) begin
                    state_d = DONE;
                    we_d    = 1'b0;
                    if (is_write_q) begin
                        rdata_d = rdata_q;
                    end else begin
                        rdata_d[DATA_WIDTH-1:SRAM_DATA_WIDTH] = i_SRAM_Read_Data;
                    end
                end else begin
                    state_d = HI;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // controller state and registered SRAM/load-data outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            word_q     <= {WORD_W{1'b0}};
            is_write_q <= 1'b0;
            store_q    <= {DATA_WIDTH{1'b0}};
            rdata_q    <= {DATA_WIDTH{1'b0}};
            addr_q     <= {SRAM_ADDR_WIDTH{1'b0}};
            wdata_q    <= {SRAM_DATA_WIDTH{1'b0}};
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            is_write_q <= is_write_d;
            store_q    <= store_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
        end
    end

    assign o_Freeze                 = ~reset & mem_req_s & (state_q != DONE);
    assign o_Sig_Write_Back_Enable  = i_Sig_Write_Back_Enable;
    assign o_Sig_Memory_Read_Enable = i_Sig_Memory_Read_Enable;
    assign o_ALU_Result             = i_ALU_Result;
    assign o_Destination            = i_Destination;
    assign o_Mem_Read_Data          = rdata_q;
    assign o_SRAM_Addr              = addr_q;
    assign o_SRAM_Write_Data        = wdata_q;
    assign o_SRAM_Write_En          = we_q;

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboarded bench for mem_stage_sram_ctrl: a WAIT_CYCLES=1 instance and a
// WAIT_CYCLES=0 instance, each backed by a simple SRAM model.
module tb_mem_stage_sram_ctrl;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        wb, rd, wr;
    logic [31:0] alu, rm;
    logic [3:0]  dest;
    logic        freeze, o_wb, o_rd, we;
    logic [31:0] o_alu, rdata;
    logic [3:0]  o_dest;
    logic [17:0] sram_addr, rd_addr_d1;
    logic [15:0] sram_wdata, sram_rdata;
    logic [15:0] mem [0:255];

    logic        rd0, wb0, wr0;
    logic [31:0] alu0, rm0;
    logic [3:0]  dest0;
    logic        freeze0, o_wb0, o_rd0, we0;
    logic [31:0] o_alu0, rdata0;
    logic [3:0]  o_dest0;
    logic [17:0] sram_addr0;
    logic [15:0] sram_wdata0, sram_rdata0;
    logic [15:0] mem0 [0:255];

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q [$];

    mem_stage_sram_ctrl #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .i_Sig_Write_Back_Enable(wb), .i_Sig_Memory_Read_Enable(rd),
        .i_Sig_Memory_Write_Enable(wr), .i_ALU_Result(alu), .i_Value_Rm(rm),
        .i_Destination(dest), .o_Freeze(freeze),
        .o_Sig_Write_Back_Enable(o_wb), .o_Sig_Memory_Read_Enable(o_rd),
        .o_ALU_Result(o_alu), .o_Destination(o_dest), .o_Mem_Read_Data(rdata),
        .o_SRAM_Addr(sram_addr), .o_SRAM_Write_Data(sram_wdata),
        .o_SRAM_Write_En(we), .i_SRAM_Read_Data(sram_rdata)
    );

    mem_stage_sram_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .i_Sig_Write_Back_Enable(wb0), .i_Sig_Memory_Read_Enable(rd0),
        .i_Sig_Memory_Write_Enable(wr0), .i_ALU_Result(alu0), .i_Value_Rm(rm0),
        .i_Destination(dest0), .o_Freeze(freeze0),
        .o_Sig_Write_Back_Enable(o_wb0), .o_Sig_Memory_Read_Enable(o_rd0),
        .o_ALU_Result(o_alu0), .o_Destination(o_dest0), .o_Mem_Read_Data(rdata0),
        .o_SRAM_Addr(sram_addr0), .o_SRAM_Write_Data(sram_wdata0),
        .o_SRAM_Write_En(we0), .i_SRAM_Read_Data(sram_rdata0)
    );

    // SRAM with one cycle of read latency behind the address
    always @(posedge clk) begin
        if (we) mem[sram_addr[7:0]] <= sram_wdata;
        rd_addr_d1 <= sram_addr;
    end
    assign sram_rdata = mem[rd_addr_d1[7:0]];

    // zero-latency SRAM for the WAIT_CYCLES=0 instance
    always @(posedge clk) begin
        if (we0) mem0[sram_addr0[7:0]] <= sram_wdata0;
    end
    assign sram_rdata0 = mem0[sram_addr0[7:0]];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [31:0] act);
        logic [31:0] e;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: scoreboard empty, got 0x%08h", name, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                tests_failed++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, e);
            end
        end
    endtask

    // drive one op at the start of a cycle and count frozen cycles until DONE
    task automatic run_op(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] v, input logic [3:0] d,
                          output int frz, output int wec);
        rd = r; wr = w; alu = a; rm = v; dest = d; wb = r;
        frz = 0; wec = 0;
        #1;
        for (int i = 0; i < 20 && freeze; i++) begin
            frz++;
            if (we) wec++;
            @(posedge clk); #1;
        end
        if (freeze) begin
            tests_run++; tests_failed++;
            $display("FAIL op_timeout: freeze still 1 after 20 cycles, expected 0");
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0; wb = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rd = 1'b0; wr = 1'b0; wb = 1'b0; alu = 32'h0; rm = 32'h0; dest = 4'h0;
        rd0 = 1'b0; wr0 = 1'b0; wb0 = 1'b0; alu0 = 32'h0; rm0 = 32'h0; dest0 = 4'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check32("reset_rdata", rdata, 32'h0);
        check32("reset_addr", {14'h0, sram_addr}, 32'h0);
        check32("reset_wdata", {16'h0, sram_wdata}, 32'h0);
        check32("reset_we", {31'h0, we}, 32'h0);
        check32("reset_freeze", {31'h0, freeze}, 32'h0);
        check32("reset_state", {30'h0, dut.state_q}, {30'h0, IDLE});
    endtask

    task automatic test_store();
        int frz, wec;
        mem[4] = 16'h0; mem[5] = 16'h0;
        exp_q.push_back(32'h12345678);
        @(posedge clk); #1;
        run_op(1'b0, 1'b1, 32'd1032, 32'h12345678, 4'h0, frz, wec);
        check32("store_freeze_len", frz, 32'd5);
        check32("store_we_cycles", wec, 32'd4);
        check32("store_we_in_done", {31'h0, we}, 32'h0);
        go_idle();
        pop_check("store_sram_contents", {mem[5], mem[4]});
    endtask

    task automatic test_load();
        int frz, wec;
        exp_q.push_back(32'h12345678);
        run_op(1'b1, 1'b0, 32'd1032, 32'h0, 4'hA, frz, wec);
        check32("load_freeze_len", frz, 32'd5);
        check32("load_we_cycles", wec, 32'd0);
        pop_check("load_data", rdata);
        check32("load_dest_pass", {28'h0, o_dest}, 32'hA);
        check32("load_wb_pass", {31'h0, o_wb}, 32'h1);
        check32("load_rd_pass", {31'h0, o_rd}, 32'h1);
        go_idle();
    endtask

    task automatic test_alu_op();
        alu = 32'hDEADBEEF; rd = 1'b0; wr = 1'b0; wb = 1'b1; dest = 4'h3;
        #1;
        check32("alu_pass", o_alu, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) begin
            check32("alu_no_freeze", {31'h0, freeze}, 32'h0);
            check32("alu_no_we", {31'h0, we}, 32'h0);
            check32("alu_addr_hold", {14'h0, sram_addr}, 32'd5);
            @(posedge clk); #1;
        end
        check32("alu_rdata_hold", rdata, 32'h12345678);
        wb = 1'b0;
    endtask

    task automatic test_back_to_back();
        int frz, wec;
        mem[0] = 16'hBEEF; mem[1] = 16'hCAFE; mem[2] = 16'h3210; mem[3] = 16'h7654;
        exp_q.push_back(32'hCAFEBEEF);
        exp_q.push_back(32'h76543210);
        run_op(1'b1, 1'b0, 32'd1024, 32'h0, 4'h1, frz, wec);
        check32("b2b_first_freeze", frz, 32'd5);
        pop_check("b2b_first_data", rdata);
        @(posedge clk); #1;
        run_op(1'b1, 1'b0, 32'd1028, 32'h0, 4'h2, frz, wec);
        check32("b2b_second_freeze", frz, 32'd5);
        pop_check("b2b_second_data", rdata);
        go_idle();
    endtask

    task automatic test_reset_mid_store();
        int frz, wec;
        mem[8] = 16'h0; mem[9] = 16'h0;
        rd = 1'b0; wr = 1'b1; alu = 32'd1040; rm = 32'hAAAA5555;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check32("midrst_we", {31'h0, we}, 32'h0);
        check32("midrst_freeze", {31'h0, freeze}, 32'h0);
        check32("midrst_addr", {14'h0, sram_addr}, 32'h0);
        check32("midrst_rdata", rdata, 32'h0);
        check32("midrst_state", {30'h0, dut.state_q}, {30'h0, IDLE});
        wr = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        check32("midrst_partial_lo", {16'h0, mem[8]}, 32'h5555);
        exp_q.push_back(32'h12345678);
        @(posedge clk); #1;
        run_op(1'b1, 1'b0, 32'd1032, 32'h0, 4'h5, frz, wec);
        check32("after_rst_freeze", frz, 32'd5);
        pop_check("after_rst_load", rdata);
        go_idle();
    endtask

    task automatic test_wait0();
        int frz = 0;
        mem0[0] = 16'h1111; mem0[1] = 16'h2222;
        exp_q.push_back(32'h22221111);
        @(posedge clk); #1;
        rd0 = 1'b1; alu0 = 32'd1024;
        #1;
        for (int i = 0; i < 20 && freeze0; i++) begin
            frz++;
            @(posedge clk); #1;
        end
        if (freeze0) begin
            tests_run++; tests_failed++;
            $display("FAIL wait0_timeout: freeze still 1, expected 0");
        end
        check32("wait0_freeze_len", frz, 32'd3);
        pop_check("wait0_data", rdata0);
        @(posedge clk); #1 rd0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_alu_op();
        test_back_to_back();
        test_reset_mid_store();
        test_wait0();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
